// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and load/store unit (B) writeback paths.
// Define RF_WB_FIXED_PRI_EN to give B fixed priority instead of round-robin arbitration.
module rf_wb_arbiter #(
   parameter int ADW = 5,
   parameter int DPW = 32
) (
   input  logic           clk,
   input  logic           arst_n,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic [ADW-1:0] a_addr,
   input  logic [DPW-1:0] a_data,
   input  logic           b_valid,
   output logic           b_ready,
   input  logic [ADW-1:0] b_addr,
   input  logic [DPW-1:0] b_data,
   input  logic [ADW-1:0] rs_1,
   input  logic [ADW-1:0] rs_2,
   output logic           haz_1,
   output logic           haz_2,
   output logic [ADW-1:0] addr_3,
   output logic           we_3,
   output logic [DPW-1:0] wd_3
);

   logic           slot_a_vld;
   logic [ADW-1:0] slot_a_addr;
   logic [DPW-1:0] slot_a_data;
   logic           slot_b_vld;
   logic [ADW-1:0] slot_b_addr;
   logic [DPW-1:0] slot_b_data;
   logic           grant_a;
   logic           grant_b;

`ifdef RF_WB_FIXED_PRI_EN
   // Loads always win a contested cycle; the ALU may starve under continuous load traffic.
   always_comb begin
      grant_b = slot_b_vld;
      grant_a = slot_a_vld && !slot_b_vld;
   end
`else
   logic rr;
   logic both;

   always_comb begin
      both    = slot_a_vld && slot_b_vld;
      grant_a = slot_a_vld && (!slot_b_vld || !rr);
      grant_b = slot_b_vld && (!slot_a_vld || rr);
   end

   // After a contested grant the pointer moves to the loser.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         rr <= 1'b0;
      else if (both)
         rr <= grant_a;
   end
`endif

   assign a_ready = !slot_a_vld || grant_a;
   assign b_ready = !slot_b_vld || grant_b;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         slot_a_vld  <= 1'b0;
         slot_a_addr <= '0;
         slot_a_data <= '0;
      end else if (a_valid && a_ready) begin
         slot_a_vld  <= 1'b1;
         slot_a_addr <= a_addr;
         slot_a_data <= a_data;
      end else if (grant_a) begin
         slot_a_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         slot_b_vld  <= 1'b0;
         slot_b_addr <= '0;
         slot_b_data <= '0;
      end else if (b_valid && b_ready) begin
         slot_b_vld  <= 1'b1;
         slot_b_addr <= b_addr;
         slot_b_data <= b_data;
      end else if (grant_b) begin
         slot_b_vld  <= 1'b0;
      end
   end

   // x0 writes still drain and update addr/data, but never raise the write enable.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         we_3   <= 1'b0;
         addr_3 <= '0;
         wd_3   <= '0;
      end else if (grant_a) begin
         we_3   <= (slot_a_addr != '0);
         addr_3 <= slot_a_addr;
         wd_3   <= slot_a_data;
      end else if (grant_b) begin
         we_3   <= (slot_b_addr != '0);
         addr_3 <= slot_b_addr;
         wd_3   <= slot_b_data;
      end else begin
         we_3   <= 1'b0;
      end
   end

   function automatic logic pending(input logic [ADW-1:0] rs);
      return (rs != '0) &&
             ((slot_a_vld && (slot_a_addr == rs)) ||
              (slot_b_vld && (slot_b_addr == rs)) ||
              (we_3 && (addr_3 == rs)));
   endfunction

   always_comb begin
      haz_1 = pending(rs_1);
      haz_2 = pending(rs_2);
   end

endmodule
